// File: rtl/score_display_scheduler.sv
// score_display_scheduler: arbitrates score/hiscore/level onto an 8-digit
// multiplexed seven-segment display via one shared double-dabble converter.
module score_display_scheduler #(
  parameter int CLOCK_FREQ = 25_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int HOLD_MS    = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] score,
  input  logic [23:0] hiscore,
  input  logic        hiscore_req,
  input  logic [7:0]  level,
  input  logic        level_req,
  input  logic        blank_lz,
  output logic [6:0]  SEG,
  output logic [7:0]  AN,
  output logic [1:0]  src,
  output logic        busy
);
  localparam int SW = $clog2(CLOCK_FREQ / SCAN_HZ + 1);
  localparam int MW = $clog2(CLOCK_FREQ / 1000 + 1);
  localparam int HW = $clog2(HOLD_MS + 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(CLOCK_FREQ / SCAN_HZ - 1);
  localparam logic [MW-1:0] MS_MAX = MW'(CLOCK_FREQ / 1000 - 1);
  localparam logic [HW-1:0] HOLD = HW'(HOLD_MS);
  localparam logic [1:0] SRC_SCORE = 2'd0, SRC_HI = 2'd1, SRC_LVL = 2'd2;
  localparam logic [3:0] CODE_L = 4'hA, CODE_BL = 4'hF;
  localparam logic [23:0] MAX_VAL = 24'd9_999_999;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

  state_t state_q, state_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [MW-1:0] ms_cnt_q, ms_cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0] src_q, src_d, win;
  logic pend_hi_q, pend_hi_d, pend_lvl_q, pend_lvl_d, refresh_q, refresh_d;
  logic [23:0] bin_q, bin_d, sel;
  logic [27:0] bcd_q, bcd_d, disp_q, disp_d;
  logic [23:0] adj;
  logic [4:0] sh_cnt_q, sh_cnt_d;
  logic [6:0] seg_q, seg_d, blk;
  logic [7:0] an_q, an_d;
  logic busy_q, busy_d;
  logic scan_tick, ms_tick, frame_end, idle, chg, restart, start, commit, above;
  logic [3:0] code;

  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'd0: glyph = 7'h3F;
      4'd1: glyph = 7'h06;
      4'd2: glyph = 7'h5B;
      4'd3: glyph = 7'h4F;
      4'd4: glyph = 7'h66;
      4'd5: glyph = 7'h6D;
      4'd6: glyph = 7'h7D;
      4'd7: glyph = 7'h07;
      4'd8: glyph = 7'h7F;
      4'd9: glyph = 7'h6F;
      CODE_L: glyph = 7'b0111000;
      default: glyph = 7'h00;
    endcase
  endfunction

  always_comb begin
    scan_tick = scan_cnt_q == SCAN_MAX;
    ms_tick = ms_cnt_q == MS_MAX;
    scan_cnt_d = scan_tick ? '0 : scan_cnt_q + 1'b1;
    ms_cnt_d = ms_tick ? '0 : ms_cnt_q + 1'b1;
    idx_d = !scan_tick ? idx_q : (idx_q == 3'd6) ? 3'd0 : idx_q + 3'd1;
    frame_end = scan_tick && idx_q == 3'd6;
    idle = state_q == IDLE;
    // grants only move while the converter is idle, so a conversion always matches src
    win = !idle ? src_q
        : (pend_lvl_q && src_q != SRC_LVL) ? SRC_LVL
        : (pend_hi_q && (src_q == SRC_SCORE || (src_q == SRC_LVL && hold_q == '0))) ? SRC_HI
        : (hold_q == '0) ? SRC_SCORE : src_q;
    chg = win != src_q;
    src_d = win;
    restart = (hiscore_req && src_q == SRC_HI) || (level_req && src_q == SRC_LVL);
    hold_d = chg ? (win == SRC_SCORE ? '0 : HOLD)
           : restart ? HOLD
           : (ms_tick && hold_q != '0) ? hold_q - 1'b1 : hold_q;
    pend_hi_d = (pend_hi_q || (hiscore_req && src_q != SRC_HI)) && !(chg && win == SRC_HI);
    pend_lvl_d = (pend_lvl_q || (level_req && src_q != SRC_LVL)) && !(chg && win == SRC_LVL);
    start = idle && !chg && (refresh_q || frame_end);
    refresh_d = chg || (refresh_q && !start);
    state_d = (state_q == IDLE) ? (start ? LOAD : IDLE)
            : (state_q == LOAD) ? SHIFT
            : (state_q == SHIFT) ? (sh_cnt_q == 5'd23 ? COMMIT : SHIFT) : IDLE;
    sel = src_q == SRC_LVL ? {16'd0, level} : src_q == SRC_HI ? hiscore : score;
    adj = '0;
    // top digit stays <= 4 before each shift once clamped, so it never needs the add-3
    for (int i = 0; i < 6; i++)
      adj[4*i +: 4] = bcd_q[4*i +: 4] + (bcd_q[4*i +: 4] >= 4'd5 ? 4'd3 : 4'd0);
    bin_d = state_q == LOAD ? (sel > MAX_VAL ? MAX_VAL : sel)
          : state_q == SHIFT ? bin_q << 1 : bin_q;
    bcd_d = state_q == LOAD ? '0 : state_q == SHIFT ? {bcd_q[26:24], adj, bin_q[23]} : bcd_q;
    sh_cnt_d = state_q == SHIFT ? sh_cnt_q + 5'd1 : 5'd0;
    commit = state_q == COMMIT;
    disp_d = !commit ? disp_q
           : src_q == SRC_LVL ? {CODE_L, {3{CODE_BL}}, bcd_q[11:0]} : bcd_q;
    above = 1'b1;
    blk = '0;
    for (int i = 6; i >= 0; i--) begin
      blk[i] = above && disp_d[4*i +: 4] == 4'd0 && i != 0;
      above = above && (disp_d[4*i +: 4] == 4'd0 || disp_d[4*i +: 4] >= CODE_L);
    end
    code = disp_d[{idx_d, 2'b00} +: 4];
    seg_d = (scan_tick || commit) ? ~glyph(blank_lz && blk[idx_d] ? CODE_BL : code) : seg_q;
    an_d = (scan_tick || commit) ? ~(8'b1 << idx_d) : an_q;
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      scan_cnt_q <= '0;
      ms_cnt_q <= '0;
      idx_q <= '0;
      hold_q <= '0;
      src_q <= SRC_SCORE;
      pend_hi_q <= 1'b0;
      pend_lvl_q <= 1'b0;
      refresh_q <= 1'b1;
      bin_q <= '0;
      bcd_q <= '0;
      sh_cnt_q <= '0;
      disp_q <= '0;
      seg_q <= 7'h7F;
      an_q <= 8'hFF;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      scan_cnt_q <= scan_cnt_d;
      ms_cnt_q <= ms_cnt_d;
      idx_q <= idx_d;
      hold_q <= hold_d;
      src_q <= src_d;
      pend_hi_q <= pend_hi_d;
      pend_lvl_q <= pend_lvl_d;
      refresh_q <= refresh_d;
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      sh_cnt_q <= sh_cnt_d;
      disp_q <= disp_d;
      seg_q <= seg_d;
      an_q <= an_d;
      busy_q <= busy_d;
    end
  end

  assign SEG = seg_q;
  assign AN = an_q;
  assign src = src_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_score_display_scheduler.sv
// tb_score_display_scheduler: directed checks of conversion, blanking, arbitration and hold timing.
module tb_score_display_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [23:0] score = 24'd1_234_567;
  logic [23:0] hiscore = '0;
  logic hiscore_req = 1'b0;
  logic [7:0] level = '0;
  logic level_req = 1'b0;
  logic blank_lz = 1'b0;
  logic [6:0] SEG;
  logic [7:0] AN;
  logic [1:0] src;
  logic busy;
  int checks = 0;
  int errors = 0;
  int ka = 0;
  int tick_n = 0;
  int n;

  score_display_scheduler #(.CLOCK_FREQ(14_000), .SCAN_HZ(1000), .HOLD_MS(3)) dut (
    .clk(clk), .reset(reset), .score(score), .hiscore(hiscore), .hiscore_req(hiscore_req),
    .level(level), .level_req(level_req), .blank_lz(blank_lz),
    .SEG(SEG), .AN(AN), .src(src), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // one cycle; optionally keeps the granted source alive with periodic request pulses
  task automatic step();
    @(negedge clk);
    tick_n++;
    hiscore_req = (ka == 1) && (tick_n % 8 == 0);
    level_req = (ka == 2) && (tick_n % 8 == 0);
  endtask

  task automatic pulse(input logic h, input logic l);
    hiscore_req = h;
    level_req = l;
    @(negedge clk);
    hiscore_req = 1'b0;
    level_req = 1'b0;
  endtask

  task automatic conv(input string tag);
    int k = 0;
    while (busy && k < 60) begin step(); k++; end
    k = 0;
    while (!busy && k < 200) begin step(); k++; end
    check({tag, "_start"}, busy, 1);
    k = 0;
    while (busy && k < 60) begin step(); k++; end
    check({tag, "_done"}, busy, 0);
  endtask

  task automatic see_digit(input string tag, input int i, input logic [6:0] exp);
    logic [7:0] a;
    int k = 0;
    a = ~(8'b1 << i);
    while (AN !== a && k < 300) begin step(); k++; end
    check({tag, "_an"}, AN, a);
    check(tag, SEG, exp);
  endtask

  task automatic wait_src(input logic [1:0] s);
    int k = 0;
    while (src !== s && k < 300) begin step(); k++; end
  endtask

  task automatic hold_len(input logic [1:0] s, output int len);
    len = 0;
    while (src === s && len < 300) begin step(); len++; end
  endtask

  initial begin
    repeat (5) @(negedge clk);
    check("rst_seg", SEG, 7'h7F);
    check("rst_an", AN, 8'hFF);
    check("rst_src", src, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    n = 0;
    while (!busy && n < 10) begin step(); n++; end
    check("first_busy", busy, 1);
    n = 0;
    while (busy && n < 60) begin step(); n++; end
    check("busy_len", n, 26);
    see_digit("first_d0", 0, 7'h78);
    see_digit("first_d1", 1, 7'h02);
    see_digit("first_d6", 6, 7'h79);
    check("an7_off", AN[7], 1);

    score = 24'd9_999_999;
    conv("c9");
    for (int i = 0; i < 7; i++) see_digit($sformatf("nines_d%0d", i), i, 7'h10);
    score = 24'd10_000_000;
    conv("clamp");
    see_digit("clamp_d0", 0, 7'h10);
    see_digit("clamp_d3", 3, 7'h10);
    see_digit("clamp_d6", 6, 7'h10);
    score = 24'd0;
    blank_lz = 1'b1;
    conv("zero");
    see_digit("zero_d0", 0, 7'h40);
    see_digit("zero_d1", 1, 7'h7F);
    see_digit("zero_d6", 6, 7'h7F);
    score = 24'd1005;
    conv("k1005");
    see_digit("k1005_d0", 0, 7'h12);
    see_digit("k1005_d1", 1, 7'h40);
    see_digit("k1005_d2", 2, 7'h40);
    see_digit("k1005_d3", 3, 7'h79);
    see_digit("k1005_d4", 4, 7'h7F);
    see_digit("k1005_d6", 6, 7'h7F);

    hiscore = 24'd42;
    pulse(1'b1, 1'b0);
    wait_src(2'd1);
    check("hi_grant", src, 1);
    ka = 1;
    conv("hi");
    see_digit("hi_d0", 0, 7'h24);
    see_digit("hi_d1", 1, 7'h19);
    see_digit("hi_d2", 2, 7'h7F);
    ka = 0;
    wait_src(2'd0);
    check("hi_back", src, 0);
    pulse(1'b1, 1'b0);
    wait_src(2'd1);
    check("hi_grant2", src, 1);
    hold_len(2'd1, n);
    check("hi_hold", (n >= 28 && n <= 72), 1);
    check("hi_after", src, 0);

    level = 8'd5;
    pulse(1'b1, 1'b1);
    wait_src(2'd2);
    check("both_lvl", src, 2);
    ka = 2;
    conv("lvl");
    see_digit("lvl_d6", 6, 7'h47);
    see_digit("lvl_d4", 4, 7'h7F);
    see_digit("lvl_d0", 0, 7'h12);
    ka = 0;
    hold_len(2'd2, n);
    check("lvl_then_hi", src, 1);
    hold_len(2'd1, n);
    check("queued_hi_hold", (n >= 28 && n <= 72), 1);
    check("queued_after", src, 0);

    pulse(1'b0, 1'b1);
    wait_src(2'd2);
    check("rs_grant", src, 2);
    repeat (20) step();
    pulse(1'b0, 1'b1);
    hold_len(2'd2, n);
    check("rs_hold", (n >= 27 && n <= 72), 1);
    check("rs_after", src, 0);

    blank_lz = 1'b0;
    score = 24'd1_234_567;
    n = 0;
    while (busy && n < 60) begin step(); n++; end
    n = 0;
    while (!busy && n < 200) begin step(); n++; end
    check("mid_load", busy, 1);
    repeat (5) step();
    pulse(1'b1, 1'b0);
    repeat (4) step();
    reset = 1'b0;
    @(negedge clk);
    check("mid_busy", busy, 0);
    check("mid_seg", SEG, 7'h7F);
    check("mid_an", AN, 8'hFF);
    check("mid_src", src, 0);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 150; i++) begin step(); if (src !== 2'd0) n++; end
    check("mid_nopend", n, 0);
    see_digit("mid_d6", 6, 7'h79);
    see_digit("mid_d0", 0, 7'h78);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule
